// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the imem read handshake, and feeds IF/ID
// with stall holding and redirects (an in-flight read on redirect completes and is discarded).
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_VALID,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTR,
    output logic        FETCH_ERR
);
    localparam logic [31:0]  NOP      = 32'h0000_0013;
    localparam int           WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH, HOLD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   pending_pc, pending_pc_nxt;
    logic [31:0]   skid, skid_nxt;
    logic [31:0]   skid_pc, skid_pc_nxt;
    logic          if_valid, if_valid_nxt;
    logic [31:0]   if_pc, if_pc_nxt;
    logic [31:0]   if_instr, if_instr_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          fetch_err, fetch_err_nxt;

    logic        resp;
    logic        slot_free;
    logic [31:0] redir_pc;

    assign IMEM_READ = (state == FETCH) || (state == FLUSH);
    assign IMEM_ADDR = fetch_pc;
    assign IF_VALID  = if_valid;
    assign IF_PC     = if_pc;
    assign IF_INSTR  = if_instr;
    assign FETCH_ERR = fetch_err;

    assign resp      = IMEM_READ && !IMEM_BUSYWAIT;
    assign slot_free = !if_valid || !STALL;
    assign redir_pc  = REDIRECT_PC & ~32'h3;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            skid       <= NOP;
            skid_pc    <= 32'h0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_instr   <= NOP;
            wait_cnt   <= '0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pending_pc <= pending_pc_nxt;
            skid       <= skid_nxt;
            skid_pc    <= skid_pc_nxt;
            if_valid   <= if_valid_nxt;
            if_pc      <= if_pc_nxt;
            if_instr   <= if_instr_nxt;
            wait_cnt   <= wait_cnt_nxt;
            fetch_err  <= fetch_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        pending_pc_nxt = pending_pc;
        skid_nxt       = skid;
        skid_pc_nxt    = skid_pc;
        if_valid_nxt   = if_valid;
        if_pc_nxt      = if_pc;
        if_instr_nxt   = if_instr;
        wait_cnt_nxt   = wait_cnt;

        // IF/ID takes the presented instruction; a load below may refill the slot.
        if (if_valid && !STALL)
            if_valid_nxt = 1'b0;

        case (state)
            BOOT: begin
                if (REDIRECT)
                    fetch_pc_nxt = redir_pc;
                state_nxt = FETCH;
            end
            FETCH: begin
                if (REDIRECT && resp) begin
                    if_valid_nxt = 1'b0;
                    fetch_pc_nxt = redir_pc;
                end else if (REDIRECT) begin
                    pending_pc_nxt = redir_pc;
                    if_valid_nxt   = 1'b0;
                    state_nxt      = FLUSH;
                end else if (resp && slot_free) begin
                    if_instr_nxt = IMEM_RDATA;
                    if_pc_nxt    = fetch_pc;
                    if_valid_nxt = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end else if (resp) begin
                    skid_nxt     = IMEM_RDATA;
                    skid_pc_nxt  = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = HOLD;
                end
            end
            FLUSH: begin
                if (REDIRECT)
                    pending_pc_nxt = redir_pc;
                if (resp) begin
                    fetch_pc_nxt = REDIRECT ? redir_pc : pending_pc;
                    state_nxt    = FETCH;
                end
            end
            HOLD: begin
                if (REDIRECT) begin
                    skid_nxt     = NOP;
                    if_valid_nxt = 1'b0;
                    fetch_pc_nxt = redir_pc;
                    state_nxt    = FETCH;
                end else if (!STALL) begin
                    if_instr_nxt = skid;
                    if_pc_nxt    = skid_pc;
                    if_valid_nxt = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase

        // Busy cycles are counted per read, including a read being flushed.
        if (resp)
            wait_cnt_nxt = '0;
        else if (IMEM_READ && IMEM_BUSYWAIT && wait_cnt < WAIT_MAX)
            wait_cnt_nxt = wait_cnt + 1'b1;

        fetch_err_nxt = fetch_err || (wait_cnt_nxt == WAIT_MAX);
    end
endmodule
